data_sram_slave: RTL and testbench
==================================

DATA_SRAM_SLAVE -- requirements
Module: data_sram_slave

Interface
REQ-001 Parameter ADDR_W, default 12, meaning word-index width; storage holds 2^ADDR_W 32-bit words.
REQ-002 Parameter RESP_DELAY, default 2, meaning cycles from request acceptance to data_ok; legal range 1..7.
REQ-003 Parameter QDEPTH, default 2, meaning maximum outstanding accepted-but-unanswered requests; legal range 1..4.
REQ-004 The block SHALL use one clock and a synchronous active-high reset.
REQ-005 clk  input  1  clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 req  input  1  initiator request valid.
REQ-008 wr  input  1  1 = store, 0 = load.
REQ-009 wstrb  input  4  byte write enables, bit i covers wdata[8i+7:8i]; ignored when wr=0.
REQ-010 addr  input  32  byte address; only addr[ADDR_W+1:2] is used.
REQ-011 wdata  input  32  store data, already byte-lane replicated by the initiator.
REQ-012 pause  input  1  test hook; when 1, no new request is accepted.
REQ-013 addr_ok  output  1  request accepted this cycle when req & addr_ok.
REQ-014 data_ok  output  1  one-cycle response strobe, in acceptance order.
REQ-015 rdata  output  32  load data, valid only while data_ok=1.

Function
REQ-016 addr_ok SHALL equal ~reset & ~pause & (count < QDEPTH), where count is the registered occupancy; a same-cycle pop SHALL NOT free a slot.
REQ-017 On acceptance with wr=1, the addressed word SHALL update at that edge in the byte lanes where wstrb=1; other lanes are unchanged.
REQ-018 On acceptance with wr=0, the addressed word SHALL be captured at that edge into the queue entry.
REQ-019 Each queue entry SHALL hold {wr, data, countdown}, with countdown loaded with RESP_DELAY-1 at acceptance and decremented by 1 each later cycle, saturating at 0.
REQ-020 data_ok SHALL be 1 in a cycle iff count>0 and head.countdown==0, so a request accepted at edge T answers in the cycle after edge T+RESP_DELAY-1.
REQ-021 When data_ok=1, rdata SHALL be head.data for loads and 32'h0 for stores; when data_ok=0, rdata SHALL be 32'h0.
REQ-022 The head SHALL pop at the edge that ends its data_ok cycle; the initiator is always ready and there is no backpressure on data_ok.
REQ-023 Queue pointers SHALL wrap modulo QDEPTH; simultaneous push and pop SHALL leave count unchanged.
REQ-024 A load accepted the cycle after a store to the same word SHALL return the post-store value.
REQ-025 pause SHALL NOT freeze countdowns or responses already queued.

Reset
REQ-026 While reset=1: count, head/tail pointers and all countdowns SHALL clear at the edge; addr_ok=0, data_ok=0, rdata=0.
REQ-027 Reset mid-operation SHALL discard all pending responses with no data_ok emitted; storage contents SHALL be retained, not cleared.

Verification
REQ-028 Default parameters; store addr=0x10, wdata=0xAABBCCDD, wstrb=4'hF accepted at edge 0, then load addr=0x10 -> data_ok in cycles 2 and 3; the second strobe returns rdata=0xAABBCCDD and the first returns 0.
REQ-029 Word 0x20 = 0x11223344; store wstrb=4'b0100, wdata=0x55555555; then load -> rdata=0x11553344.
REQ-030 req held at 1 with loads for 4 cycles (QDEPTH=2, RESP_DELAY=2) -> addr_ok pattern 1,1,0,1 and responses returned in order, each exactly 2 cycles after acceptance.
REQ-031 Two loads outstanding, reset asserted for 1 cycle -> no data_ok afterwards, count=0, and addr_ok=1 in the cycle after reset deasserts.
REQ-032 pause=1 with req=1 for 3 cycles while one load is pending -> addr_ok=0 throughout, and the pending data_ok still fires on schedule.
REQ-033 addr=0xFFFF_C010 and addr=0x0000_0010 -> both alias to the same word (index 4).

Source files
------------

// File: rtl/data_sram_slave.sv
// -----------------------------------------------------------------------------
// data_sram_slave
//
// Word-addressed 32-bit SRAM slave with a split request/response handshake.
// A request is accepted in any cycle where req & addr_ok. Stores update the
// storage at the accepting edge. Loads capture the addressed word at the
// accepting edge. Every accepted request (load or store) then produces exactly
// one data_ok strobe, RESP_DELAY cycles later, in acceptance order.
//
// Handshake: req/addr_ok is a valid/ready pair. A transfer happens on a rising
// edge where both are 1. addr_ok never depends on req. data_ok has no ready
// side: the initiator must take the strobe in the cycle it is raised.
//
// Parameters
//   ADDR_W     word-index width; storage holds 2^ADDR_W words
//   RESP_DELAY cycles from acceptance to data_ok (1..7)
//   QDEPTH     maximum accepted-but-unanswered requests (1..4)
//
// Ports
//   clk      clock, all state changes on the rising edge
//   reset    synchronous active-high reset (storage is not cleared)
//   req      request valid
//   wr       1 = store, 0 = load
//   wstrb    byte write enables for stores
//   addr     byte address; only addr[ADDR_W+1:2] selects the word
//   wdata    store data, byte-lane replicated by the initiator
//   pause    when 1, no new request is accepted
//   addr_ok  ready for a request this cycle
//   data_ok  one-cycle response strobe
//   rdata    load data while data_ok=1, otherwise zero
// -----------------------------------------------------------------------------
module data_sram_slave #(
    parameter int ADDR_W     = 12,
    parameter int RESP_DELAY = 2,
    parameter int QDEPTH     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        pause,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = $clog2(QDEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(QDEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(QDEPTH);
    localparam logic [2:0]       CD_INIT  = 3'(RESP_DELAY - 1);

    // Storage (never reset)
    logic [31:0] mem [DEPTH];

    // Response queue: payload and per-entry countdown
    logic        q_wr   [QDEPTH];
    logic [31:0] q_data [QDEPTH];
    logic [2:0]  q_cd   [QDEPTH];

    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    logic [ADDR_W-1:0] idx;
    logic              push;
    logic              pop;

    // Byte offset and bits above the word index are deliberately ignored,
    // so addresses differing only there alias to the same word.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[31:ADDR_W+2], addr[1:0]};

    assign idx = addr[ADDR_W+1:2];

    // Occupancy is the registered count: a pop in this cycle does not make
    // room for a push in the same cycle.
    assign addr_ok = ~reset & ~pause & (count < CNT_MAX);
    assign push    = req & addr_ok;

    assign data_ok = ~reset & (count != '0) & (q_cd[head] == 3'd0);
    assign pop     = data_ok;
    assign rdata   = (data_ok & ~q_wr[head]) ? q_data[head] : 32'h0;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Storage write, byte-lane masked
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (push && wr && wstrb[b]) begin
                mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // Queue payload. A load reads the storage as it stands before this edge;
    // since only one request is accepted per edge, a store accepted at the
    // previous edge is already visible.
    always_ff @(posedge clk) begin
        if (push) begin
            q_wr[tail]   <= wr;
            q_data[tail] <= wr ? 32'h0 : mem[idx];
        end
    end

    // Queue control: pointers, occupancy and countdowns
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            head  <= '0;
            tail  <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                q_cd[i] <= 3'd0;
            end
        end else begin
            // Countdowns keep running regardless of pause; the slot being
            // pushed is always free, so loading it cannot disturb a live entry.
            for (int i = 0; i < QDEPTH; i++) begin
                if (push && (tail == PTR_W'(i))) begin
                    q_cd[i] <= CD_INIT;
                end else if (q_cd[i] != 3'd0) begin
                    q_cd[i] <= q_cd[i] - 3'd1;
                end
            end

            if (push) begin
                tail <= ptr_next(tail);
            end
            if (pop) begin
                head <= ptr_next(head);
            end

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_data_sram_slave.sv
// -----------------------------------------------------------------------------
// tb_data_sram_slave
//
// Bench for data_sram_slave at default parameters. The reference model is a
// word array plus a queue of expected responses, each tagged with the cycle in
// which its data_ok is due. Inputs change 1 time unit after the rising edge;
// outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_data_sram_slave;

    localparam int ADDR_W = 12;
    localparam int RD     = 2;
    localparam int QD     = 2;
    localparam int NWORDS = 16;

    // ------------------------------------------------------------------ clock
    logic clk = 1'b1;
    always #5 clk = ~clk;

    logic        reset;
    logic        req;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        pause;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    data_sram_slave #(
        .ADDR_W    (ADDR_W),
        .RESP_DELAY(RD),
        .QDEPTH    (QD)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .wr     (wr),
        .wstrb  (wstrb),
        .addr   (addr),
        .wdata  (wdata),
        .pause  (pause),
        .addr_ok(addr_ok),
        .data_ok(data_ok),
        .rdata  (rdata)
    );

    // -------------------------------------------------------------- scoreboard
    logic [31:0] mem_model [1 << ADDR_W];
    logic [31:0] exp_q[$];
    int          due_q[$];

    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          dok_seen = 0;
    logic [31:0] last_rdata = 32'h0;
    logic [3:0]  ok_hist = 4'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: check outputs against the model, advance the model,
    // then move past the next rising edge.
    task automatic step();
        logic        e_ok;
        logic        e_dok;
        logic [31:0] e_rd;
        int          w;
        @(negedge clk);
        e_ok  = !reset && !pause && (exp_q.size() < QD);
        e_dok = !reset && (exp_q.size() > 0) && (due_q[0] == cyc);
        e_rd  = e_dok ? exp_q[0] : 32'h0;
        check("addr_ok", {31'b0, addr_ok}, {31'b0, e_ok});
        check("data_ok", {31'b0, data_ok}, {31'b0, e_dok});
        check("rdata", rdata, e_rd);
        ok_hist = {ok_hist[2:0], addr_ok};
        if (data_ok) begin
            dok_seen++;
            last_rdata = rdata;
        end
        if (reset) begin
            exp_q.delete();
            due_q.delete();
        end else begin
            if (e_dok) begin
                void'(exp_q.pop_front());
                void'(due_q.pop_front());
            end
            if (req && e_ok) begin
                w = int'(addr[ADDR_W+1:2]);
                if (wr) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wstrb[b]) mem_model[w][8*b +: 8] = wdata[8*b +: 8];
                    end
                    exp_q.push_back(32'h0);
                end else begin
                    exp_q.push_back(mem_model[w]);
                end
                due_q.push_back(cyc + RD);
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // ----------------------------------------------------------------- drivers
    task automatic drive(input logic r, input logic w, input logic [3:0] s,
                         input logic [31:0] a, input logic [31:0] d);
        req   = r;
        wr    = w;
        wstrb = s;
        addr  = a;
        wdata = d;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        for (int i = 0; i < n; i++) step();
    endtask

    // Random upper and byte-offset bits around a word index, to exercise aliasing.
    function automatic logic [31:0] word_addr(input int w);
        logic [31:0] hi;
        hi = $urandom;
        return (hi << (ADDR_W + 2)) | (32'(w) << 2) | 32'($urandom_range(0, 3));
    endfunction

    // ---------------------------------------------------------------- stimulus
    int dok_before;

    initial begin
        reset = 1'b1;
        pause = 1'b0;
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        step();
        step();
        reset = 1'b0;
        idle(1);

        // Give every word the bench uses a known value
        for (int i = 0; i < NWORDS; i++) begin
            drive(1'b1, 1'b1, 4'hF, word_addr(i), $urandom);
            step();
            idle(2);
        end

        // Store then load of the same word on consecutive cycles
        drive(1'b1, 1'b1, 4'hF, 32'h0000_0010, 32'hAABB_CCDD);
        step();
        drive(1'b1, 1'b0, 4'h0, 32'h0000_0010, 32'h0);
        step();
        idle(3);
        check("store_load_rdata", last_rdata, 32'hAABB_CCDD);

        // Partial-strobe store
        drive(1'b1, 1'b1, 4'hF, 32'h0000_0020, 32'h1122_3344);
        step();
        idle(2);
        drive(1'b1, 1'b1, 4'b0100, 32'h0000_0020, 32'h5555_5555);
        step();
        drive(1'b1, 1'b0, 4'h0, 32'h0000_0020, 32'h0);
        step();
        idle(3);
        check("wstrb_merge", last_rdata, 32'h1155_3344);

        // Address aliasing: upper bits ignored
        drive(1'b1, 1'b1, 4'hF, 32'hFFFF_C010, 32'hCAFE_F00D);
        step();
        idle(2);
        drive(1'b1, 1'b0, 4'h0, 32'h0000_0010, 32'h0);
        step();
        idle(3);
        check("alias_rdata", last_rdata, 32'hCAFE_F00D);

        // Back-to-back loads fill the queue
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 4'h0, word_addr(i), 32'h0);
            step();
        end
        check("addr_ok_pattern", {28'b0, ok_hist}, {28'b0, 4'b1101});
        idle(4);

        // Reset with two loads outstanding drops both responses
        drive(1'b1, 1'b0, 4'h0, word_addr(5), 32'h0);
        step();
        drive(1'b1, 1'b0, 4'h0, word_addr(6), 32'h0);
        step();
        dok_before = dok_seen;
        reset = 1'b1;
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        step();
        reset = 1'b0;
        step();
        check("addr_ok_after_reset", {31'b0, ok_hist[0]}, 32'd1);
        idle(4);
        check("no_dok_after_reset", 32'(dok_seen - dok_before), 32'd0);

        // Pause blocks acceptance but not the pending response
        drive(1'b1, 1'b0, 4'h0, word_addr(7), 32'h0);
        step();
        dok_before = dok_seen;
        pause = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("pause_addr_ok", {29'b0, ok_hist[2:0]}, 32'd0);
        check("pause_dok_fired", 32'(dok_seen - dok_before), 32'd1);
        pause = 1'b0;
        idle(3);

        // Random traffic, including occasional pause and reset
        for (int i = 0; i < 500; i++) begin
            reset = ($urandom_range(0, 63) == 0);
            pause = ($urandom_range(0, 7) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  4'($urandom_range(0, 15)), word_addr($urandom_range(0, NWORDS - 1)),
                  $urandom);
            step();
        end
        reset = 1'b0;
        pause = 1'b0;
        idle(6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
